// File: rtl/mem_access_pkg.sv
// Shared types for the load/store sequencer.
// Access sizes, FSM states and the byte-enable mask helper.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_WORD  = 2'd1,
    SZ_DWORD = 2'd2
  } access_size_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_DONE
  } mas_state_t;

  // n low bytes set; n never exceeds 8 here
  function automatic logic [7:0] byte_mask(
    input logic [3:0] n
  );
    return 8'((9'd1 << n) - 9'd1);
  endfunction

endpackage

// File: rtl/byte_lane_rotator.sv
// Byte-granular rotate left/right of a bus word.
// Output bytes whose mask bit is clear are forced to zero.
module byte_lane_rotator #(
  parameter int BUS_BYTES = 2,
  localparam int DW = 8 * BUS_BYTES,
  localparam int LB = $clog2(BUS_BYTES)
) (
  input  logic [DW-1:0]        din,
  input  logic [LB-1:0]        amt,
  input  logic                 left,
  input  logic [BUS_BYTES-1:0] mask,
  output logic [DW-1:0]        dout
);

  always_comb begin
    logic [LB-1:0] src;
    src  = '0;
    dout = '0;
    for (int i = 0; i < BUS_BYTES; i++) begin
      src = left ? LB'(i) - amt : LB'(i) + amt;
      if (mask[i])
        dout[8*i +: 8] = din[8*int'(src) +: 8];
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer: seg:off address, split
// unaligned accesses into two lane-steered bus beats.
module mem_access_sequencer
  import mem_access_pkg::*;
#(
  parameter int BUS_BYTES = 2,
  parameter int ADDR_W = 20,
  localparam int DW = 8 * BUS_BYTES,
  localparam int LB = $clog2(BUS_BYTES),
  localparam int AW = ADDR_W - LB
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          segment,
  input  logic [15:0]          offset,
  input  logic                 io,
  input  logic                 wr_en,
  input  logic [1:0]           size,
  input  logic [DW-1:0]        wdata,
  output logic                 busy,
  output logic                 complete,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        m_addr,
  output logic [DW-1:0]        m_data_out,
  input  logic [DW-1:0]        m_data_in,
  output logic                 m_access,
  input  logic                 m_ack,
  output logic                 m_wr_en,
  output logic [BUS_BYTES-1:0] m_bytesel
);

  mas_state_t state, state_n;

  logic [ADDR_W-1:0]    lin, lin_n;
  logic                 wr_q;
  logic [DW-1:0]        wdata_q;
  logic [2:0]           nb_q, nb_n;
  logic [2:0]           k_q, k_n;
  logic                 two_q, two_n;
  logic                 size_ok;
  logic [LB-1:0]        lane, lane_n;
  logic [AW-1:0]        word;
  logic                 beat0, beat1;
  logic                 accept, ack;
  logic [LB-1:0]        amt;
  logic [BUS_BYTES-1:0] sel0, sel1;
  logic [BUS_BYTES-1:0] smask, lmask;
  logic [DW-1:0]        st_dout, ld_dout;

  assign lane   = lin[LB-1:0];
  assign word   = lin[ADDR_W-1:LB];
  assign accept = (state == S_IDLE) && start;
  assign ack    = (beat0 || beat1) && m_ack;

  // Illegal sizes fall back to a 2-byte access
  always_comb begin
    nb_n    = 3'd2;
    size_ok = 1'b0;
    unique case (1'b1)
      size == SZ_BYTE: begin
        nb_n    = 3'd1;
        size_ok = 1'b1;
      end
      size == SZ_WORD: begin
        nb_n    = 3'd2;
        size_ok = 1'b1;
      end
      size == SZ_DWORD && BUS_BYTES >= 4: begin
        nb_n    = 3'd4;
        size_ok = 1'b1;
      end
      default: ;
    endcase
    lin_n = io ? ADDR_W'(offset)
               : ADDR_W'({segment, 4'h0})
                 + ADDR_W'(offset);
    lane_n = lin_n[LB-1:0];
    two_n  = (4'(lane_n) + 4'(nb_n))
             > 4'(BUS_BYTES);
    k_n    = two_n ? 3'(BUS_BYTES - int'(lane_n))
                   : nb_n;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_BEAT0;
      S_BEAT0: if (m_ack)
                 state_n = two_q ? S_BEAT1 : S_DONE;
      S_BEAT1: if (m_ack) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lin     <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      nb_q    <= 3'd0;
      k_q     <= 3'd0;
      two_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        lin     <= lin_n;
        wr_q    <= wr_en;
        wdata_q <= wdata;
        nb_q    <= nb_n;
        k_q     <= k_n;
        two_q   <= two_n;
        if (!wr_en) rdata <= '0;
      end
      // beats fill disjoint byte ranges of a cleared word
      if (ack && !wr_q)
        rdata <= rdata | ld_dout;
    end
  end

  always_comb begin
    beat0 = (state == S_BEAT0);
    beat1 = (state == S_BEAT1);
    sel0  = BUS_BYTES'(
              byte_mask({1'b0, nb_q}) << lane);
    sel1  = BUS_BYTES'(
              byte_mask({1'b0, nb_q - k_q}));
    amt   = beat1 ? LB'(k_q) : lane;
    smask = beat1
      ? BUS_BYTES'(byte_mask(
          4'(BUS_BYTES) - {1'b0, k_q}))
      : BUS_BYTES'(~byte_mask(4'(lane)));
    lmask = beat1
      ? BUS_BYTES'(byte_mask({1'b0, nb_q})
          & ~byte_mask({1'b0, k_q}))
      : BUS_BYTES'(byte_mask({1'b0, k_q}));
    m_access   = beat0 || beat1;
    busy       = beat0 || beat1;
    complete   = (state == S_DONE);
    m_wr_en    = m_access && wr_q;
    m_addr     = beat0 ? word
               : beat1 ? word + AW'(1) : '0;
    m_bytesel  = beat0 ? sel0
               : beat1 ? sel1 : '0;
    m_data_out = m_access ? st_dout : '0;
  end

  byte_lane_rotator #(
    .BUS_BYTES (BUS_BYTES)
  ) u_store (
    .din  (wdata_q),
    .amt  (amt),
    .left (~beat1),
    .mask (smask),
    .dout (st_dout)
  );

  byte_lane_rotator #(
    .BUS_BYTES (BUS_BYTES)
  ) u_load (
    .din  (m_data_in),
    .amt  (amt),
    .left (beat1),
    .mask (lmask),
    .dout (ld_dout)
  );

  a_size_legal : assert property (
    @(posedge clk) disable iff (reset)
    accept |-> size_ok
  );

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer,
// 2-byte and 4-byte bus instances side by side.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start2, start4;
  logic [15:0] seg, off;
  logic        io, wr_en;
  logic [1:0]  size;
  logic [31:0] wdata, md;
  logic        m_ack;
  logic        b4;

  logic        busy2, complete2, access2, wr2;
  logic [15:0] rdata2, dout2;
  logic [18:0] addr2;
  logic [1:0]  sel2;
  logic        busy4, complete4, access4, wr4;
  logic [31:0] rdata4, dout4;
  logic [17:0] addr4;
  logic [3:0]  sel4;

  logic        c_busy, c_complete, c_access, c_wr;
  logic [31:0] c_rdata, c_addr, c_sel, c_dout;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_sequencer #(.BUS_BYTES(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .start      (start2),
    .segment    (seg),
    .offset     (off),
    .io         (io),
    .wr_en      (wr_en),
    .size       (size),
    .wdata      (wdata[15:0]),
    .busy       (busy2),
    .complete   (complete2),
    .rdata      (rdata2),
    .m_addr     (addr2),
    .m_data_out (dout2),
    .m_data_in  (md[15:0]),
    .m_access   (access2),
    .m_ack      (m_ack),
    .m_wr_en    (wr2),
    .m_bytesel  (sel2)
  );

  mem_access_sequencer #(.BUS_BYTES(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .start      (start4),
    .segment    (seg),
    .offset     (off),
    .io         (io),
    .wr_en      (wr_en),
    .size       (size),
    .wdata      (wdata),
    .busy       (busy4),
    .complete   (complete4),
    .rdata      (rdata4),
    .m_addr     (addr4),
    .m_data_out (dout4),
    .m_data_in  (md),
    .m_access   (access4),
    .m_ack      (m_ack),
    .m_wr_en    (wr4),
    .m_bytesel  (sel4)
  );

  always_comb begin
    if (b4) begin
      c_busy     = busy4;
      c_complete = complete4;
      c_access   = access4;
      c_wr       = wr4;
      c_rdata    = rdata4;
      c_addr     = 32'(addr4);
      c_sel      = 32'(sel4);
      c_dout     = dout4;
    end else begin
      c_busy     = busy2;
      c_complete = complete2;
      c_access   = access2;
      c_wr       = wr2;
      c_rdata    = 32'(rdata2);
      c_addr     = 32'(addr2);
      c_sel      = 32'(sel2);
      c_dout     = 32'(dout2);
    end
  end

  typedef struct {
    logic        b4;
    logic [15:0] seg;
    logic [15:0] off;
    logic        io;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        two;
    logic [31:0] a0;
    logic [31:0] s0;
    logic [31:0] o0;
    logic [31:0] a1;
    logic [31:0] s1;
    logic [31:0] o1;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic do_beat(input logic [31:0] a,
                         input logic [31:0] s,
                         input logic [31:0] o,
                         input logic wr,
                         input logic [31:0] din,
                         input int waits,
                         input string tag);
    for (int w = 0; w <= waits; w++) begin
      chk({tag, ".access"}, 32'(c_access), 1);
      chk({tag, ".busy"}, 32'(c_busy), 1);
      chk({tag, ".complete"}, 32'(c_complete), 0);
      chk({tag, ".addr"}, c_addr, a);
      chk({tag, ".sel"}, c_sel, s);
      chk({tag, ".dout"}, c_dout, o);
      chk({tag, ".wr"}, 32'(c_wr), 32'(wr));
      if (w == waits) begin
        md    = din;
        m_ack = 1'b1;
      end
      step();
      m_ack = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v,
                         input string tag);
    b4    = v.b4;
    seg   = v.seg;
    off   = v.off;
    io    = v.io;
    wr_en = v.wr;
    size  = v.size;
    wdata = v.wdata;
    if (v.b4) start4 = 1'b1;
    else      start2 = 1'b1;
    step();
    start2 = 1'b0;
    start4 = 1'b0;
    do_beat(v.a0, v.s0, v.o0, v.wr, v.d0,
            0, {tag, ".b0"});
    if (v.two)
      do_beat(v.a1, v.s1, v.o1, v.wr, v.d1,
              0, {tag, ".b1"});
    chk({tag, ".done"}, 32'(c_complete), 1);
    chk({tag, ".done_busy"}, 32'(c_busy), 0);
    chk({tag, ".done_acc"}, 32'(c_access), 0);
    chk({tag, ".rdata"}, c_rdata, v.rd);
    step();
    chk({tag, ".pulse"}, 32'(c_complete), 0);
  endtask

  initial begin
    vt[0] = '{1'b0, 16'h1234, 16'h0005, 1'b0, 1'b0,
      2'd1, 32'h0, 32'hAB00, 32'h00CD, 1'b1,
      32'h91A2, 32'h2, 32'h0,
      32'h91A3, 32'h1, 32'h0, 32'hCDAB};
    vt[1] = '{1'b0, 16'h0000, 16'h0011, 1'b1, 1'b1,
      2'd0, 32'h005A, 32'h0, 32'h0, 1'b0,
      32'h8, 32'h2, 32'h5A00,
      32'h0, 32'h0, 32'h0, 32'hCDAB};
    vt[2] = '{1'b0, 16'hFFFF, 16'h001F, 1'b0, 1'b1,
      2'd1, 32'hBEEF, 32'h0, 32'h0, 1'b1,
      32'h7, 32'h2, 32'hEF00,
      32'h8, 32'h1, 32'h00BE, 32'hCDAB};
    vt[3] = '{1'b0, 16'h0000, 16'h0100, 1'b0, 1'b0,
      2'd1, 32'h0, 32'h1234, 32'h0, 1'b0,
      32'h80, 32'h3, 32'h0,
      32'h0, 32'h0, 32'h0, 32'h1234};
    vt[4] = '{1'b0, 16'h0001, 16'h0003, 1'b0, 1'b0,
      2'd0, 32'h0, 32'h7788, 32'h0, 1'b0,
      32'h9, 32'h2, 32'h0,
      32'h0, 32'h0, 32'h0, 32'h0077};
    vt[5] = '{1'b1, 16'h0000, 16'h0003, 1'b0, 1'b0,
      2'd2, 32'h0, 32'h44000000, 32'h00332211,
      1'b1, 32'h0, 32'h8, 32'h0,
      32'h1, 32'h7, 32'h0, 32'h33221144};
    vt[6] = '{1'b1, 16'h0000, 16'h0006, 1'b1, 1'b1,
      2'd2, 32'hA1B2C3D4, 32'h0, 32'h0, 1'b1,
      32'h1, 32'hC, 32'hC3D40000,
      32'h2, 32'h3, 32'h0000A1B2, 32'h33221144};
    vt[7] = '{1'b1, 16'h0010, 16'h0002, 1'b0, 1'b0,
      2'd1, 32'h0, 32'hBEEF0000, 32'h0, 1'b0,
      32'h40, 32'hC, 32'h0,
      32'h0, 32'h0, 32'h0, 32'h0000BEEF};
    vt[8] = '{1'b1, 16'h0000, 16'h0007, 1'b1, 1'b1,
      2'd0, 32'h000000C3, 32'h0, 32'h0, 1'b0,
      32'h1, 32'h8, 32'hC3000000,
      32'h0, 32'h0, 32'h0, 32'h0000BEEF};

    reset  = 1'b1;
    start2 = 1'b0;
    start4 = 1'b0;
    seg    = '0;
    off    = '0;
    io     = 1'b0;
    wr_en  = 1'b0;
    size   = 2'd0;
    wdata  = '0;
    md     = '0;
    m_ack  = 1'b0;
    b4     = 1'b0;
    step();
    step();
    reset = 1'b0;

    for (int d = 0; d < 2; d++) begin
      b4 = (d == 1);
      chk("rst.busy", 32'(c_busy), 0);
      chk("rst.complete", 32'(c_complete), 0);
      chk("rst.access", 32'(c_access), 0);
      chk("rst.wr", 32'(c_wr), 0);
      chk("rst.rdata", c_rdata, 0);
      chk("rst.addr", c_addr, 0);
      chk("rst.sel", c_sel, 0);
      chk("rst.dout", c_dout, 0);
    end

    // stray ack while idle
    b4    = 1'b0;
    m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    chk("stray.busy", 32'(c_busy), 0);
    chk("stray.access", 32'(c_access), 0);
    chk("stray.complete", 32'(c_complete), 0);
    step();
    chk("stray.complete2", 32'(c_complete), 0);

    for (int i = 0; i < 9; i++)
      run_vec(vt[i], $sformatf("vec%0d", i));

    // wait states with a competing start
    b4    = 1'b0;
    seg   = 16'h0000;
    off   = 16'h0021;
    io    = 1'b0;
    wr_en = 1'b0;
    size  = 2'd1;
    wdata = '0;
    start2 = 1'b1;
    step();
    off = 16'h0FFF;
    do_beat(32'h10, 32'h2, 32'h0, 1'b0,
            32'h5500, 3, "wait.b0");
    start2 = 1'b0;
    do_beat(32'h11, 32'h1, 32'h0, 1'b0,
            32'h0066, 1, "wait.b1");
    chk("wait.done", 32'(c_complete), 1);
    chk("wait.rdata", c_rdata, 32'h6655);
    step();
    chk("wait.pulse", 32'(c_complete), 0);
    chk("wait.idle", 32'(c_busy), 0);

    // reset while the second beat waits
    off    = 16'h0021;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    do_beat(32'h10, 32'h2, 32'h0, 1'b0,
            32'h9900, 0, "abort.b0");
    chk("abort.in_b1", c_addr, 32'h11);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort.access", 32'(c_access), 0);
    chk("abort.busy", 32'(c_busy), 0);
    chk("abort.rdata", c_rdata, 0);
    chk("abort.complete", 32'(c_complete), 0);
    chk("abort.addr", c_addr, 0);
    chk("abort.sel", c_sel, 0);
    step();
    chk("abort.complete2", 32'(c_complete), 0);
    chk("abort.busy2", 32'(c_busy), 0);
    run_vec(vt[3], "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
